// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry, synchronous flush and an occupancy count.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  entry_t                      i_push_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output entry_t                      o_head,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  entry_t          r_mem [DEPTH];
  entry_t          r_head;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic            w_push;
  logic            w_pop;
  logic [PtrW-1:0] w_rd_next;
  logic [CntW-1:0] w_remain;
  entry_t          w_head_next;

  assign w_pop     = i_pop && (r_count != '0);
  assign w_push    = i_push && ((r_count != Full) || w_pop);
  assign w_rd_next = r_rd_ptr + PtrW'(w_pop);
  assign w_remain  = r_count - CntW'(w_pop);

  // The entry written this cycle becomes the head directly when nothing older remains.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push && (w_remain == '0)) begin
      w_head_next = i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      r_count <= w_remain + CntW'(w_push);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
    r_head <= w_head_next;
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order response buffering and redirect with
// stale-response discard. Define FETCH_PERF_CNT_EN to add request/drop/stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        Stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] CreditLim = SumW'(DEPTH);

  logic            r_rst_q;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_rsp_pc;
  logic [CntW-1:0] r_outstanding;
  logic [CntW-1:0] r_discard;

  logic [CntW-1:0] w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic [SumW-1:0] w_credit_used;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [CntW-1:0] w_outstanding_next;
  logic [31:0]     w_target;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  // Queued entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
  assign w_credit_used  = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !r_rst_q && (w_credit_used < CreditLim);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_target           = {redirect_pc[31:2], 2'b00};
  assign w_drop             = imem_rsp_valid && (redirect || (r_discard != '0));
  assign w_push             = imem_rsp_valid && !w_drop;
  assign w_pop              = inst_valid && !Stall;
  assign w_outstanding_next = r_outstanding + CntW'(w_req_fire) - CntW'(imem_rsp_valid);
  assign w_push_entry       = '{addr: r_rsp_pc, inst: imem_rsp_data};

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_drop) begin
          r_discard <= r_discard - CntW'(1);
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(fetch_entry_t)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst_out   = inst_valid ? w_head.inst : NOP_INST;
  assign inst_addr  = inst_valid ? w_head.addr : 32'h0;

  // A response with nothing in flight means the memory side was not reset with this stage.
  assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (r_outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_req;
  logic [31:0] r_perf_drop;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_req   <= '0;
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_req   <= r_perf_req + 32'(w_req_fire);
      r_perf_drop  <= r_perf_drop + 32'(w_drop);
      r_perf_stall <= r_perf_stall + 32'(inst_valid && Stall);
    end
  end

  assign perf_req_cnt   = r_perf_req;
  assign perf_drop_cnt  = r_perf_drop;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with random latency, epoch-tagged scoreboard, random stimulus.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        Stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .Stall         (Stall),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_addr     (inst_addr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_req_cnt  (perf_req_cnt),
    .perf_drop_cnt (perf_drop_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int          due;
  } req_t;

  req_t         pend[$];   // requests accepted by memory, oldest first
  fetch_entry_t sb[$];     // instructions the decode side should see, oldest first

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic [31:0] exp_pc = RESET_PC;
  int          n_fires = 0;
  int          n_drops = 0;
  int          n_stall = 0;
  int          n_deliv = 0;
  int          first_fire_cyc = -1;
  int          first_valid_cyc = -1;
  logic        last_rst = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Memory: answers the oldest accepted request once its latency has elapsed.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst && (pend.size() > 0) && (pend[0].due <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Monitor: checks this cycle's outputs against the start-of-cycle model state.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (last_rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst_out", inst_out, NOP_INST);
      chk("rst_inst_addr", inst_addr, 32'h0);
    end
    if (!rst) begin
      chk("req_valid", 32'(imem_req_valid),
          32'(!last_rst && ((pend.size() + sb.size()) < DEPTH)));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
      if (!inst_valid) begin
        chk("empty_inst_out", inst_out, NOP_INST);
        chk("empty_inst_addr", inst_addr, 32'h0);
      end else if (first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
      end
      if (inst_valid && !Stall && !redirect) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_inst: got addr %h inst %h, expected none", inst_addr,
                   inst_out);
        end else begin
          e = sb.pop_front();
          chk("inst_addr", inst_addr, e.addr);
          chk("inst_out", inst_out, e.inst);
          n_deliv++;
        end
      end
    end
    last_rst = rst;
  end

  // Reference model: applies this cycle's events once the monitor has looked at it.
  always @(negedge clk) begin
    req_t         r;
    fetch_entry_t e;
    logic         fire;
    #2;
    fire = imem_req_valid && imem_req_ready;
    if (rst) begin
      pend.delete();
      sb.delete();
      exp_pc  = RESET_PC;
      epoch   = 0;
      n_fires = 0;
      n_drops = 0;
      n_stall = 0;
    end else begin
      if ((sb.size() != 0) && Stall) n_stall++;
      if (imem_rsp_valid && (pend.size() > 0)) begin
        r = pend.pop_front();
        if (!redirect && (r.epoch == epoch)) begin
          e.addr = r.addr;
          e.inst = mem_word(r.addr);
          sb.push_back(e);
        end else begin
          n_drops++;
        end
      end
      if (fire) begin
        n_fires++;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        pend.push_back('{addr: exp_pc, epoch: epoch,
                         due: cyc + int'($urandom_range(lat_max, lat_min))});
      end
      if (redirect) begin
        sb.delete();
        epoch++;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (fire) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for the head to appear and check its address.
  task automatic wait_head(input string name, input logic [31:0] exp_addr);
    bit found = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
    end
    if (found) begin
      chk(name, inst_addr, exp_addr);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, expected head %h", name, exp_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          d0;
    logic [31:0] hold;

    repeat (3) step();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    repeat (20) step();
    chk("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd2);
    d0 = n_deliv;
    repeat (10) step();
    chk("throughput", 32'(n_deliv - d0), 32'd10);

    Stall = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("stall_full_req_valid", 32'(imem_req_valid), 32'h0);
    step();
    Stall = 1'b0;
    repeat (3) step();

    imem_req_ready = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("ready_low_req_valid", 32'(imem_req_valid), 32'h1);
    hold = exp_pc;
    step();
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("ready_release_addr", imem_req_addr, hold);
    step();
    @(negedge clk);
    chk("single_fire_advance", imem_req_addr, hold + 32'd4);
    step();

    lat_min = 2;
    lat_max = 2;
    repeat (10) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("flush_empty", 32'(inst_valid), 32'h0);
    wait_head("redirect_head_100", 32'h0000_0100);

    lat_min = 1;
    lat_max = 1;
    repeat (10) step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    chk("redirect_cycle_fire", 32'(imem_req_valid && imem_req_ready), 32'h1);
    chk("redirect_cycle_rsp", 32'(imem_rsp_valid), 32'h1);
    step();
    redirect = 1'b0;
    wait_head("redirect_head_200", 32'h0000_0200);

    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    step();
    redirect_pc = 32'h0000_0800;
    step();
    redirect = 1'b0;
    wait_head("back_to_back_head", 32'h0000_0800);

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) lat_max = $urandom_range(3, 1);
      imem_req_ready = ($urandom_range(9, 0) < 7);
      Stall = ($urandom_range(3, 0) == 0);
      redirect = ($urandom_range(39, 0) == 0);
      redirect_pc = $urandom;
      step();
    end

    redirect = 1'b0;
    Stall = 1'b0;
    imem_req_ready = 1'b1;
    lat_max = 1;
    repeat (5) step();
    d0 = n_deliv;
    repeat (20) step();
    chk("drain_progress", 32'(n_deliv - d0 >= 10), 32'h1);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    chk("perf_req_cnt", perf_req_cnt, 32'(n_fires));
    chk("perf_drop_cnt", perf_drop_cnt, 32'(n_drops));
    chk("perf_stall_cnt", perf_stall_cnt, 32'(n_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
